// File: rtl/dmb_axil_pkg.sv
// ============================================================================
//  Module      : dmb_axil_pkg
//  Description : Shared types and constants for the CPU data-memory-bus to
//                AXI4-lite bridge: FSM state encoding, AXI response codes and
//                the legal address window used by the optional range check
//                (enabled with the DMB_ADDR_CHECK_EN macro).
//                The window bounds come from the platform macros
//                addrBASE_RAM, addrBASE_mtimer and SIZE_MTIMER. Fallback
//                values are supplied when the platform defines are absent.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef addrBASE_RAM
`define addrBASE_RAM 32'h0000_1000
`endif
`ifndef addrBASE_mtimer
`define addrBASE_mtimer 32'h0002_0000
`endif
`ifndef SIZE_MTIMER
`define SIZE_MTIMER 32'h0000_0010
`endif

package dmb_axil_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_AW_W = 3'd1,
      ST_WR_B    = 3'd2,
      ST_RD_AR   = 3'd3,
      ST_RD_R    = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam logic [1:0] c_RESP_OKAY   = 2'b00;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;
   localparam logic [1:0] c_RESP_DECERR = 2'b11;

   // Window is [LO, HI); HI is kept 64 bits wide so base+size cannot wrap.
   localparam logic [63:0] c_RANGE_LO = 64'(`addrBASE_RAM);
   localparam logic [63:0] c_RANGE_HI = 64'(`addrBASE_mtimer) + 64'(`SIZE_MTIMER);

   function automatic logic addr_in_range(input logic [63:0] i_addr);
      return (i_addr >= c_RANGE_LO) && (i_addr < c_RANGE_HI);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmb_axil_master.sv
// ============================================================================
//  Module      : dmb_axil_master
//  Description : Bridges the CPU data-memory request/grant/rvalid bus onto an
//                AXI4-lite master port, one transaction outstanding at a time.
//                Optional macro DMB_ADDR_CHECK_EN: requests outside the legal
//                address window complete immediately with data_err=1 and
//                never reach AXI.
//  Ports       : clk_i, rst_i (async, active-high)
//                CPU side : data_req/gnt/rvalid/we/be/addr/wdata/rdata/err
//                AXI side : AW (awaddr/awvalid/awready), W (wdata/wstrb/
//                           wvalid/wready), B (bvalid/bresp/bready),
//                           AR (araddr/arvalid/arready),
//                           R (rvalid/rresp/rdata/rready)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmb_axil_master
   import dmb_axil_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 32,
   parameter int SW = DW / 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   // CPU data-memory slave port
   input  logic          data_req,
   output logic          data_gnt,
   output logic          data_rvalid,
   input  logic          data_we,
   input  logic [SW-1:0] data_be,
   input  logic [AW-1:0] data_addr,
   input  logic [DW-1:0] data_wdata,
   output logic [DW-1:0] data_rdata,
   output logic          data_err,
   // AXI4-lite master port
   output logic [AW-1:0] awaddr,
   output logic          awvalid,
   input  logic          awready,
   output logic [DW-1:0] wdata,
   output logic [SW-1:0] wstrb,
   output logic          wvalid,
   input  logic          wready,
   input  logic          bvalid,
   input  logic [1:0]    bresp,
   output logic          bready,
   output logic [AW-1:0] araddr,
   output logic          arvalid,
   input  logic          arready,
   input  logic          rvalid,
   input  logic [1:0]    rresp,
   input  logic [DW-1:0] rdata,
   output logic          rready
);

   state_t        r_state;
   state_t        w_state_nxt;

   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [SW-1:0] r_be;
   logic          r_we;
   logic [DW-1:0] r_rdata;
   logic          r_err;
   logic          r_aw_done;
   logic          r_w_done;

   logic          w_grant;
   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_resp_hs;
   logic [1:0]    w_resp;

`ifdef DMB_ADDR_CHECK_EN
   logic          w_addr_bad;
   assign w_addr_bad = !addr_in_range(64'(data_addr));
`endif

   assign w_grant   = (r_state == ST_IDLE) && data_req;
   assign w_aw_hs   = awvalid && awready;
   assign w_w_hs    = wvalid && wready;
   assign w_resp_hs = ((r_state == ST_WR_B) && bvalid) || ((r_state == ST_RD_R) && rvalid);
   assign w_resp    = r_we ? bresp : rresp;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (data_req) begin
`ifdef DMB_ADDR_CHECK_EN
               if (w_addr_bad)   w_state_nxt = ST_DONE;
               else if (data_we) w_state_nxt = ST_WR_AW_W;
               else              w_state_nxt = ST_RD_AR;
`else
               w_state_nxt = data_we ? ST_WR_AW_W : ST_RD_AR;
`endif
            end
         end
         // AW and W may finish in either order or together; leave only
         // when each has been accepted, counting this cycle's handshakes.
         ST_WR_AW_W: begin
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = ST_WR_B;
         end
         ST_WR_B:  if (bvalid)  w_state_nxt = ST_DONE;
         ST_RD_AR: if (arready) w_state_nxt = ST_RD_R;
         ST_RD_R:  if (rvalid)  w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      data_gnt    = w_grant;
      awvalid     = (r_state == ST_WR_AW_W) && !r_aw_done;
      wvalid      = (r_state == ST_WR_AW_W) && !r_w_done;
      bready      = (r_state == ST_WR_B);
      arvalid     = (r_state == ST_RD_AR);
      rready      = (r_state == ST_RD_R);
      data_rvalid = (r_state == ST_DONE);
      data_rdata  = r_rdata;
      data_err    = r_err;
      awaddr      = r_addr;
      araddr      = r_addr;
      wdata       = r_wdata;
      wstrb       = r_be;
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_we      <= 1'b0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
      end else begin
         if (w_grant) begin
            r_addr    <= data_addr;
            r_wdata   <= data_wdata;
            r_be      <= data_be;
            r_we      <= data_we;
            // Cleared here so writes (and rejected requests) return zero data.
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef DMB_ADDR_CHECK_EN
            r_err     <= w_addr_bad;
`else
            r_err     <= 1'b0;
`endif
         end
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
         if (w_resp_hs) r_err <= (w_resp != c_RESP_OKAY);
         if ((r_state == ST_RD_R) && rvalid) r_rdata <= rdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dmb_axil_master.sv
// ============================================================================
//  Module      : tb_dmb_axil_master
//  Description : Self-checking bench for dmb_axil_master. A configurable AXI
//                slave (per-channel ready latency, response delay) drives the
//                bus; a transaction-level model predicts grant, completion
//                data/error and latency, and a negedge compare process checks
//                the DUT every cycle. Honours DMB_ADDR_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmb_axil_master;
   import dmb_axil_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int SW = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          data_req, data_gnt, data_rvalid, data_we, data_err;
   logic [SW-1:0] data_be;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_wdata, data_rdata;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;

   always #5 clk_i = ~clk_i;

   dmb_axil_master #(.DW(DW), .AW(AW), .SW(SW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_err(data_err),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rvalid(rvalid), .rresp(rresp), .rdata(rdata), .rready(rready)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=timeout required=completion", name);
   endtask

   // ------------------------------------------------------------ slave knobs
   int         aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0; // -1: random
   logic [1:0] nxt_bresp = 2'b00, nxt_rresp = 2'b00;
   logic [31:0] nxt_rdata = '0;

   function automatic logic rdy(input int lat, input int seen);
      if (lat < 0) return 1'($urandom_range(0, 1));
      return seen >= lat;
   endfunction

   function automatic int dly(input int lat);
      if (lat < 0) return int'($urandom_range(0, 3));
      return lat;
   endfunction

   // ------------------------------------------------------------ AXI slave
   initial begin
      int aw_seen = 0, w_seen = 0, ar_seen = 0, b_cnt = -1, r_cnt = -1;
      bit got_aw = 0, got_w = 0, hs_aw, hs_w, hs_ar, hs_b, hs_r;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      forever begin
         @(negedge clk_i);
         hs_aw = awvalid && awready;  hs_w = wvalid && wready;
         hs_ar = arvalid && arready;  hs_b = bvalid && bready;
         hs_r  = rvalid && rready;
         if (awvalid && !hs_aw) aw_seen++;
         if (wvalid  && !hs_w)  w_seen++;
         if (arvalid && !hs_ar) ar_seen++;
         @(posedge clk_i); #1;
         if (rst_i) begin
            aw_seen = 0; w_seen = 0; ar_seen = 0; b_cnt = -1; r_cnt = -1;
            got_aw = 0; got_w = 0;
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
            continue;
         end
         if (hs_aw) begin got_aw = 1; aw_seen = 0; end
         if (hs_w)  begin got_w  = 1; w_seen  = 0; end
         if (hs_ar) begin ar_seen = 0; r_cnt = dly(r_lat); end
         if (got_aw && got_w) begin got_aw = 0; got_w = 0; b_cnt = dly(b_lat); end
         if (hs_b) bvalid = 0;
         if (hs_r) rvalid = 0;
         if (b_cnt == 0) begin bvalid = 1; bresp = nxt_bresp; b_cnt = -1; end
         else if (b_cnt > 0) b_cnt--;
         if (r_cnt == 0) begin rvalid = 1; rresp = nxt_rresp; rdata = nxt_rdata; r_cnt = -1; end
         else if (r_cnt > 0) r_cnt--;
         awready = rdy(aw_lat, aw_seen);
         wready  = rdy(w_lat, w_seen);
         arready = rdy(ar_lat, ar_seen);
      end
   end

   // ------------------------------------------------- model + compare process
   bit          busy = 0, zw = 0, done_flag = 0, moor = 0, mwe = 0;
   logic [31:0] maddr, mwdata, exp_rdata, last_rdata, seen_awaddr, seen_wdata;
   logic [3:0]  mbe, seen_wstrb;
   logic        exp_err, last_err;
   int          cyc = 0, t_gnt = 0, t_rv = 0, rv_count = 0, gnt_count = 0;
   int          t_aw_last = 0, t_w_last = 0, t_b_first = -1;

   function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMB_ADDR_CHECK_EN
      return (64'(a) < c_RANGE_LO) || (64'(a) >= c_RANGE_HI);
`else
      return 1'b0;
`endif
   endfunction

   initial begin
      bit p_awv = 0, p_awh = 0, p_wv = 0, p_wh = 0, p_arv = 0, p_arh = 0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (rst_i) begin
            busy = 0; p_awv = 0; p_awh = 0; p_wv = 0; p_wh = 0; p_arv = 0; p_arh = 0;
            continue;
         end
         check("gnt", data_gnt, data_req && !busy);
         if (!busy) begin
            check("idle_quiet", {awvalid, wvalid, arvalid, bready, rready, data_rvalid}, 6'b0);
         end else begin
            if (!mwe || moor) check("no_write_chan", {awvalid, wvalid}, 2'b0);
            if (mwe || moor)  check("no_read_chan", arvalid, 1'b0);
            if (awvalid) check("awaddr", awaddr, maddr);
            if (wvalid) begin
               check("wdata", wdata, mwdata);
               check("wstrb", wstrb, mbe);
            end
            if (arvalid) check("araddr", araddr, maddr);
            if (p_awv && !p_awh) check("awvalid_hold", awvalid, 1'b1);
            if (p_wv && !p_wh)   check("wvalid_hold", wvalid, 1'b1);
            if (p_arv && !p_arh) check("arvalid_hold", arvalid, 1'b1);
            if (awvalid && awready) seen_awaddr = awaddr;
            if (wvalid && wready) begin seen_wstrb = wstrb; seen_wdata = wdata; end
            if (awvalid) t_aw_last = cyc;
            if (wvalid)  t_w_last  = cyc;
            if (bready && t_b_first < 0) t_b_first = cyc;
            if (data_rvalid) begin
               check("rdata", data_rdata, exp_rdata);
               check("err", data_err, exp_err);
               if (zw) check("latency", cyc - t_gnt, moor ? 1 : 3);
               last_rdata = data_rdata; last_err = data_err;
               t_rv = cyc; rv_count++;
               busy = 0; done_flag = 1;
            end
         end
         p_awv = awvalid; p_awh = awvalid && awready;
         p_wv  = wvalid;  p_wh  = wvalid && wready;
         p_arv = arvalid; p_arh = arvalid && arready;
         if (data_gnt && data_req) begin
            busy = 1; t_gnt = cyc; gnt_count++; t_b_first = -1;
            mwe = data_we; maddr = data_addr; mwdata = data_wdata; mbe = data_be;
            moor = out_of_range(data_addr);
            exp_err   = moor ? 1'b1 : (data_we ? (nxt_bresp != 2'b00) : (nxt_rresp != 2'b00));
            exp_rdata = (moor || data_we) ? 32'h0 : nxt_rdata;
         end
      end
   end

   // --------------------------------------------------------------- driver
   task automatic set_knobs(input int a, input int w, input int ar, input int b, input int r);
      aw_lat = a; w_lat = w; ar_lat = ar; b_lat = b; r_lat = r;
      zw = (a == 0) && (w == 0) && (ar == 0) && (b == 0) && (r == 0);
   endtask

   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input bit garble);
      int n = 0;
      done_flag = 0;
      data_req = 1; data_we = we; data_addr = addr; data_wdata = wd; data_be = be;
      forever begin
         @(negedge clk_i);
         if (data_gnt) break;
         if (++n > 100) begin timeout("grant_wait"); data_req = 0; return; end
      end
      @(posedge clk_i); #1;
      n = 0;
      while (!done_flag) begin
         if (garble) begin
            data_req = 1'($urandom_range(0, 1)); data_we = 1'($urandom_range(0, 1));
            data_addr = $urandom; data_wdata = $urandom; data_be = 4'($urandom);
         end else begin
            data_req = 0;
         end
         @(posedge clk_i); #1;
         if (++n > 200) begin timeout("rvalid_wait"); break; end
      end
      data_req = 0;
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      int n, t_prev;
      data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
      #1 rst_i = 1;
      #2;  // before any clock edge: reset must act asynchronously
      check("rst_ctrl", {awvalid, wvalid, arvalid, bready, rready, data_rvalid, data_err}, 7'b0);
      check("rst_rdata", data_rdata, 32'h0);
      check("rst_addr", {awaddr, araddr}, 64'h0);
      check("rst_wdata", {wdata, wstrb}, 36'h0);
      repeat (3) @(posedge clk_i);
      #1 rst_i = 0;
      @(posedge clk_i); #1;

      // zero-wait write
      set_knobs(0, 0, 0, 0, 0); nxt_bresp = c_RESP_OKAY; rv_count = 0;
      do_txn(1, 32'h4010, 32'hDEAD_BEEF, 4'hF, 0);
      check("wr_awaddr", seen_awaddr, 32'h4010);
      check("wr_wstrb", seen_wstrb, 4'hF);
      check("wr_wdata", seen_wdata, 32'hDEAD_BEEF);
      check("wr_lat", t_rv - t_gnt, 3);
      check("wr_err", last_err, 1'b0);
      check("wr_once", rv_count, 1);

      // zero-wait read
      nxt_rresp = c_RESP_OKAY; nxt_rdata = 32'hCAFE_0001;
      do_txn(0, 32'h8010, 32'h0, 4'h0, 0);
      check("rd_lat", t_rv - t_gnt, 3);
      check("rd_data", last_rdata, 32'hCAFE_0001);

      // read with five arready wait cycles
      set_knobs(0, 0, 5, 0, 0); nxt_rdata = 32'h1234_5678; rv_count = 0; gnt_count = 0;
      do_txn(0, 32'h8010, 32'h0, 4'h0, 0);
      check("rdw_data", last_rdata, 32'h1234_5678);
      check("rdw_once", rv_count, 1);
      check("rdw_gnt_once", gnt_count, 1);

      // AW accepted one wait in, W three waits in
      set_knobs(1, 3, 0, 0, 0); rv_count = 0;
      do_txn(1, 32'h4020, 32'h0BAD_F00D, 4'h3, 0);
      check("ww_aw_last", t_aw_last - t_gnt, 2);
      check("ww_w_last", t_w_last - t_gnt, 4);
      check("ww_bready", t_b_first - t_gnt, 5);
      check("ww_once", rv_count, 1);

      // SLVERR read, then back-to-back grant
      set_knobs(0, 0, 0, 0, 0); nxt_rresp = c_RESP_SLVERR; nxt_rdata = 32'h55AA_55AA;
      do_txn(0, 32'h4000, 32'h0, 4'h0, 0);
      check("slverr_err", last_err, 1'b1);
      t_prev = t_rv; nxt_rresp = c_RESP_OKAY;
      do_txn(0, 32'h4004, 32'h0, 4'h0, 0);
      check("b2b_gnt", t_gnt - t_prev, 1);
      check("b2b_err", last_err, 1'b0);

      // reset while waiting in RD_R
      set_knobs(0, 0, 0, 0, 6); rv_count = 0; nxt_rdata = 32'h7777_0000;
      data_req = 1; data_we = 0; data_addr = 32'h4100;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!data_gnt && n < 50);
      @(posedge clk_i); #1 data_req = 0;
      n = 0;
      do begin @(negedge clk_i); n++; end while (!rready && n < 50);
      if (!rready) timeout("rready_wait");
      #2 rst_i = 1;
      #1;
      check("mid_rst_ctrl", {awvalid, wvalid, arvalid, bready, rready, data_rvalid}, 6'b0);
      check("mid_rst_rdata", data_rdata, 32'h0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 0;
      repeat (10) @(posedge clk_i);
      #1 check("rst_no_rvalid", rv_count, 0);
      set_knobs(0, 0, 0, 0, 0); nxt_rdata = 32'h600D_600D;
      do_txn(0, 32'h4100, 32'h0, 4'h0, 0);
      check("post_rst_data", last_rdata, 32'h600D_600D);

      // low address: rejected with the range check, normal read without
      nxt_rdata = 32'hABCD_0100;
      do_txn(0, 32'h0000_0100, 32'h0, 4'h0, 0);
`ifdef DMB_ADDR_CHECK_EN
      check("oor_lat", t_rv - t_gnt, 1);
      check("oor_err", last_err, 1'b1);
      check("oor_data", last_rdata, 32'h0);
`else
      check("low_lat", t_rv - t_gnt, 3);
      check("low_data", last_rdata, 32'hABCD_0100);
`endif

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         logic [1:0]  rsp[4];
         rsp[0] = c_RESP_OKAY; rsp[1] = 2'b01; rsp[2] = c_RESP_SLVERR; rsp[3] = c_RESP_DECERR;
         if ($urandom_range(0, 3) == 0) set_knobs(0, 0, 0, 0, 0);
         else set_knobs(int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 4)) - 1,
                        int'($urandom_range(0, 4)) - 1, int'($urandom_range(0, 4)) - 1,
                        int'($urandom_range(0, 4)) - 1);
         nxt_bresp = rsp[$urandom_range(0, 3)];
         nxt_rresp = rsp[$urandom_range(0, 3)];
         nxt_rdata = $urandom;
         a = ($urandom_range(0, 1) == 1) ? 32'(c_RANGE_LO) + $urandom_range(0, 32'h1000) : $urandom;
         do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk_i);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmb_axil_master.md
DMB_AXIL_MASTER -- requirements
Module: dmb_axil_master

Interface
REQ-001 SHALL have parameters: DW 32 data width; AW 32 address width; SW 4 strobe width (DW/8).
REQ-002 SHALL have ports clk_i in 1 clock; rst_i in 1 reset, asynchronous and active-high.
REQ-003 SHALL have the CPU-side data-memory slave port:
- data_req in 1: request.
- data_gnt out 1: grant.
- data_rvalid out 1: completion pulse.
- data_we in 1: write enable.
- data_be in SW: byte enables.
- data_addr in AW: address.
- data_wdata in DW: write data.
- data_rdata out DW: read data.
- data_err out 1: error, valid with data_rvalid.
REQ-004 SHALL have the AXI4-lite master port:
- awaddr out AW; awvalid out 1; awready in 1.
- wdata out DW; wstrb out SW; wvalid out 1; wready in 1.
- bvalid in 1; bresp in 2; bready out 1.
- araddr out AW; arvalid out 1; arready in 1.
- rvalid in 1; rresp in 2; rdata in DW; rready out 1.

Function
REQ-005 SHALL keep at most one transaction outstanding; the FSM states SHALL be IDLE, WR_AW_W, WR_B, RD_AR, RD_R and DONE.
REQ-006 In IDLE, data_gnt SHALL equal data_req combinationally; in all other states it SHALL be 0.
REQ-007 On grant, addr, wdata, be and we SHALL be registered, and the FSM SHALL move to WR_AW_W if we=1, else to RD_AR.
REQ-008 In WR_AW_W, awvalid and wvalid SHALL both assert in the first cycle.
- Each SHALL drop independently the cycle after its own handshake (valid and ready both high).
- The FSM SHALL go to WR_B once both handshakes are done, including when they complete in the same cycle.
REQ-009 awvalid, wvalid and arvalid SHALL never deassert before their handshake, and address, data and strobe SHALL be stable while valid is high.
REQ-010 In WR_B, bready SHALL be 1; on bvalid the FSM SHALL go to DONE, latching err = (bresp != 0).
REQ-011 In RD_AR, arvalid SHALL be 1; on arready the FSM SHALL go to RD_R.
REQ-012 In RD_R, rready SHALL be 1; on rvalid the FSM SHALL latch rdata and err = (rresp != 0), then go to DONE.
REQ-013 In DONE, data_rvalid SHALL be 1 for exactly one cycle with data_rdata and data_err; for writes data_rdata SHALL be 0. The FSM SHALL then return to IDLE.
REQ-014 Minimum latency with zero-wait slave (ready=1, response the cycle after address): request at T -> data_rvalid at T+3.
REQ-015 A new grant SHALL be possible in the cycle after data_rvalid.
REQ-016 data_req deasserting while the FSM is busy SHALL NOT affect the outstanding transaction.

Reset
REQ-017 rst_i SHALL force, asynchronously, FSM=IDLE and awvalid, wvalid, arvalid, bready, rready, data_rvalid, data_err = 0.
REQ-018 rst_i SHALL also clear data_rdata, awaddr, araddr, wdata and wstrb to 0.
REQ-019 Reset mid-transaction SHALL abandon the transaction with no data_rvalid; late bvalid/rvalid from the slave SHALL be ignored, as bready and rready are 0 in IDLE.

Configuration
REQ-020 With DMB_ADDR_CHECK_EN defined, a granted request whose address is outside [addrBASE_RAM, addrBASE_mtimer + size_mtimer) SHALL bypass AXI entirely.
- The FSM SHALL go directly to DONE with data_err=1 and data_rdata=0.
- Latency for such a request SHALL be request at T -> data_rvalid at T+1.
REQ-021 Without DMB_ADDR_CHECK_EN, every granted request SHALL issue on AXI, and the range logic SHALL be absent.

Structure
REQ-022 A package dmb_axil_pkg SHALL hold the FSM state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) and range-check bounds derived from defines.sv macros.
REQ-023 The module SHALL be flat with no sub-module; an outer wrapper MAY bind it to the CPUdataMemBus.Slave and AXI4bus.Master modports.

Verification
REQ-024 Write to addr 0x4010, be=4'hF, wdata=0xDEADBEEF, slave ready=1, bresp=OKAY -> awaddr=0x4010, wstrb=F, data_rvalid at T+3 with data_err=0.
REQ-025 Read from 0x8010, slave returns rdata=0x12345678 after 5 wait cycles on arready -> data_rdata=0x12345678, data_rvalid exactly once, data_gnt=0 throughout.
REQ-026 Write with awready at T+2 and wready at T+4 -> awvalid drops at T+3, wvalid at T+5, bready rises at T+5, single data_rvalid.
REQ-027 Read with rresp=SLVERR -> data_err=1 with data_rvalid; the next request is granted the cycle after.
REQ-028 rst_i pulse while in RD_R -> all valids and readies 0 immediately, no data_rvalid; a subsequent read completes normally.
REQ-029 With DMB_ADDR_CHECK_EN, read of 0x0000_0100 -> arvalid stays 0, data_rvalid at T+1 with data_err=1.
